smem_mem_drain: RTL and testbench
=================================

// Module: smem_mem_drain
// PURPOSE
//  Reader side of the backward-extension mem storage. The control pipeline writes SMEM entries via
//  store_valid_mem/mem_x_* and raises finish_sign with read_num/mem_size when a read completes.
//  This block queues finish events, reads entries 0..mem_size-1 back from the mem buffer, and
//  emits them as 512-bit lines over a valid/ready stream: one header line, then two entries per line.
// PARAMETERS
//  READ_NUM_WIDTH  6   read-number width; matches the `READ_NUM_WIDTH define.
//  FIFO_DEPTH      8   depth of the finish-event FIFO; power of 2, >=4.
//  CL              512 output line width; fixed, matches the `CL define.
// PORTS
//  clk              in   1    clock
//  rst              in   1    asynchronous active-low reset
//  finish_sign      in   1    1-cycle pulse: a read's mem entries are complete
//  finish_read_num  in   RNW  read number for finish_sign
//  finish_mem_size  in   7    entry count for finish_sign, 0..127
//  stall_req        out  1    to pipeline stall: FIFO occupancy >= FIFO_DEPTH-1
//  mem_rd_en        out  1    mem buffer read strobe
//  mem_rd_read_num  out  RNW  read number to fetch
//  mem_rd_addr      out  7    entry index to fetch
//  mem_rd_x_0/1/2   in   64   entry x0/x1/x2; valid exactly 1 cycle after mem_rd_en
//  mem_rd_x_info    in   64   entry info; same timing
//  out_valid        out  1    line valid
//  out_ready        in   1    sink accepts the line
//  out_data         out  512  line payload
//  out_last         out  1    final line of the current read
//  out_read_num     out  RNW  read number of the current line
//  overflow         out  1    sticky: finish_sign dropped because the FIFO was full
//  lines_sent       out  32   stats (see CONFIGURATION)
//  reads_done       out  32   stats (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output 0. FIFO is empty, FSM is in IDLE, counters and overflow are 0.
//  Reset may assert at any time. An in-flight line is discarded and out_valid drops asynchronously.
//  FIFO: pushes {read_num,mem_size} when finish_sign=1 and (not full, or a pop occurs the same cycle).
//   - Full with no pop: the event is dropped and overflow is set; only reset clears it.
//   - Push on empty: the entry is visible to the FSM the next cycle.
//  FSM states IDLE, HDR, RD0, RD1, EMIT:
//   IDLE: if FIFO non-empty, pop into cur_rn/cur_size, set idx=0, go to HDR.
//   HDR: out_valid=1, out_data[6:0]=cur_size, [7+:RNW]=cur_rn, all other bits 0.
//    out_last=(cur_size==0). Hold until out_ready. On accept: to IDLE if size==0, else to RD0.
//   RD0: mem_rd_en=1, addr=idx, then RD1.
//   RD1: capture the entry for idx into [255:0]. If idx+1<cur_size, mem_rd_en=1 with addr=idx+1.
//    Then EMIT.
//   EMIT: capture the second entry into [511:256] one cycle after its read; otherwise [511:256]=0.
//    out_valid asserts only once the line is complete.
//    out_last=1 when idx+2>=cur_size. Hold until out_ready.
//    On accept: idx+=2 (8-bit arithmetic, no wrap at 127), then RD0, or IDLE if last.
//  Entry layout in a 256-bit half: x0[63:0], x1[127:64], x2[191:128], info[255:192].
//  out_data, out_last and out_read_num hold stable while out_valid=1 and out_ready=0.
//  Line count per read = 1 + ceil(mem_size/2). Minimum line-to-line gap with out_ready=1 is 3 cycles.
//  finish_sign and a FIFO pop in the same cycle are both honoured; occupancy is unchanged.
// CONFIGURATION
//  DRAIN_STATS_EN defined:
//   - lines_sent increments on every out_valid&out_ready.
//   - reads_done increments on each accepted line with out_last=1.
//   - Both are 32-bit and wrap from 2^32-1 to 0.
//  DRAIN_STATS_EN undefined: lines_sent and reads_done are tied to 0 and no counter flops are built.
// TESTING
//  Event rn=5, size=3, out_ready=1 -> header {rn=5,size=3}, then line0 = e0|e1, line1 = e2|0;
//   out_last only on line1; reads at addr 0,1,2.
//  Event size=0 -> one header line with out_last=1 and no mem_rd_en.
//  Event size=127 -> 65 lines; last line upper half is 0; addr never exceeds 126.
//  out_ready=0 for 10 cycles mid-read -> out_data stable, no extra mem_rd_en, resumes correctly.
//  9 finish_sign pulses with the sink blocked (DEPTH=8)
//   -> stall_req=1 at occupancy 7, overflow=1 on the 9th, 8 reads drained afterwards.
//  rst low during EMIT -> all outputs 0 immediately; next event after release drains normally.
//   With DRAIN_STATS_EN, counters read 0.

Source files
------------

// File: rtl/smem_mem_drain_if.sv
// ---------------------------------------------------------------------------
// smem_mem_drain_if
//   Bundles the two bus-like port groups of the SMEM mem drain:
//     - the mem buffer read port (strobe/read number/address out, entry back
//       one cycle later), and
//     - the 512-bit valid/ready output line stream.
//   master : the drain side (smem_mem_drain)
//   slave  : the environment side (mem buffer + line sink)
//   RNW must equal the drain's READ_NUM_WIDTH.
// ---------------------------------------------------------------------------
interface smem_mem_drain_if #(
  parameter int RNW = 6
);
  // mem buffer read port
  logic           mem_rd_en;
  logic [RNW-1:0] mem_rd_read_num;
  logic [6:0]     mem_rd_addr;
  logic [63:0]    mem_rd_x_0;
  logic [63:0]    mem_rd_x_1;
  logic [63:0]    mem_rd_x_2;
  logic [63:0]    mem_rd_x_info;

  // output line stream
  logic           out_valid;
  logic           out_ready;
  logic [511:0]   out_data;
  logic           out_last;
  logic [RNW-1:0] out_read_num;

  modport master (
    output mem_rd_en, mem_rd_read_num, mem_rd_addr,
    input  mem_rd_x_0, mem_rd_x_1, mem_rd_x_2, mem_rd_x_info,
    output out_valid, out_data, out_last, out_read_num,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_read_num, mem_rd_addr,
    output mem_rd_x_0, mem_rd_x_1, mem_rd_x_2, mem_rd_x_info,
    input  out_valid, out_data, out_last, out_read_num,
    output out_ready
  );
endinterface

// File: rtl/smem_mem_drain.sv
// ---------------------------------------------------------------------------
// smem_mem_drain
//   Reader side of the backward-extension mem storage. Finish events
//   {read_num, mem_size} are queued in a small FIFO; for each event the FSM
//   emits one header line and then reads entries 0..mem_size-1 from the mem
//   buffer, packing two entries per 512-bit output line.
//
// Ports
//   clk              clock
//   rst              asynchronous active-low reset
//   finish_sign      1-cycle pulse: a read's mem entries are complete
//   finish_read_num  read number of the finish event
//   finish_mem_size  entry count of the finish event (0..127)
//   stall_req        FIFO occupancy >= FIFO_DEPTH-1
//   overflow         sticky: a finish event was dropped (FIFO full)
//   lines_sent       accepted line count (stats build only, else 0)
//   reads_done       accepted last-line count (stats build only, else 0)
//   bus              smem_mem_drain_if.master: mem read port + line stream
//
// Build option
//   DRAIN_STATS_EN   when defined, builds the 32-bit wrapping lines_sent /
//                    reads_done counters; otherwise both are tied to 0.
//
// State | meaning
//   IDLE | waiting for a queued finish event; pops it and builds the header
//   HDR  | header line offered; leaves on accept
//   RD0  | read strobe for entry idx
//   RD1  | capture entry idx into the low half; read idx+1 if it exists
//   EMIT | first cycle completes the upper half, then offers the line
// ---------------------------------------------------------------------------
module smem_mem_drain #(
  parameter int READ_NUM_WIDTH = 6,
  parameter int FIFO_DEPTH     = 8,
  parameter int CL             = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      finish_sign,
  input  logic [READ_NUM_WIDTH-1:0] finish_read_num,
  input  logic [6:0]                finish_mem_size,
  output logic                      stall_req,
  output logic                      overflow,
  output logic [31:0]               lines_sent,
  output logic [31:0]               reads_done,
  smem_mem_drain_if.master          bus
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int EW   = READ_NUM_WIDTH + 7;
  localparam int HALF = CL / 2;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_STAL = (PW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_EMIT = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Finish-event FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [EW-1:0] fifo_head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts the event then.
  assign push = finish_sign && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (finish_sign && !push) overflow_d = 1'b1;
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {finish_read_num, finish_mem_size};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign stall_req = (cnt_q >= CNT_STAL);
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [READ_NUM_WIDTH-1:0] rn_q, rn_d;
  logic [6:0]                size_q, size_d;
  logic [7:0]                idx_q, idx_d;
  logic [CL-1:0]             line_q, line_d;
  logic                      full_q, full_d;   // EMIT: upper half settled
  logic                      pend_q, pend_d;   // second entry read issued

  logic                      out_valid_c;
  logic                      out_last_c;
  logic                      rd_en_c;
  logic [6:0]                rd_addr_c;
  logic [7:0]                idx_p1, idx_p2, size8;
  logic [HALF-1:0]           entry_w;

  assign idx_p1  = idx_q + 8'd1;
  assign idx_p2  = idx_q + 8'd2;
  assign size8   = {1'b0, size_q};
  assign entry_w = {bus.mem_rd_x_info, bus.mem_rd_x_2, bus.mem_rd_x_1, bus.mem_rd_x_0};

  always_comb begin
    state_d     = state_q;
    rn_d        = rn_q;
    size_d      = size_q;
    idx_d       = idx_q;
    line_d      = line_q;
    full_d      = full_q;
    pend_d      = pend_q;
    pop         = 1'b0;
    rd_en_c     = 1'b0;
    rd_addr_c   = '0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop                        = 1'b1;
          rn_d                       = fifo_head[EW-1:7];
          size_d                     = fifo_head[6:0];
          idx_d                      = '0;
          line_d                     = '0;
          line_d[6:0]                = fifo_head[6:0];
          line_d[7 +: READ_NUM_WIDTH] = fifo_head[EW-1:7];
          state_d                    = S_HDR;
        end
      end

      S_HDR: begin
        out_valid_c = 1'b1;
        out_last_c  = (size_q == 7'd0);
        if (bus.out_ready) state_d = out_last_c ? S_IDLE : S_RD0;
      end

      S_RD0: begin
        rd_en_c   = 1'b1;
        rd_addr_c = idx_q[6:0];
        state_d   = S_RD1;
      end

      S_RD1: begin
        line_d[HALF-1:0]  = entry_w;
        line_d[CL-1:HALF] = '0;
        full_d            = 1'b0;
        if (idx_p1 < size8) begin
          rd_en_c   = 1'b1;
          rd_addr_c = idx_p1[6:0];
          pend_d    = 1'b1;
        end else begin
          pend_d    = 1'b0;
        end
        state_d = S_EMIT;
      end

      S_EMIT: begin
        if (!full_q) begin
          // Second entry lands this cycle; an odd tail keeps the zeroed half.
          if (pend_q) line_d[CL-1:HALF] = entry_w;
          pend_d = 1'b0;
          full_d = 1'b1;
        end else begin
          out_valid_c = 1'b1;
          out_last_c  = (idx_p2 >= size8);
          if (bus.out_ready) begin
            idx_d   = idx_p2;
            full_d  = 1'b0;
            state_d = out_last_c ? S_IDLE : S_RD0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rn_q    <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      line_q  <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
    end
  end

  // Payload is gated by valid so the stream reads all-zero between lines.
  assign bus.out_valid       = out_valid_c;
  assign bus.out_last        = out_last_c;
  assign bus.out_data        = out_valid_c ? line_q : '0;
  assign bus.out_read_num    = out_valid_c ? rn_q : '0;
  assign bus.mem_rd_en       = rd_en_c;
  assign bus.mem_rd_addr     = rd_addr_c;
  assign bus.mem_rd_read_num = rd_en_c ? rn_q : '0;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef DRAIN_STATS_EN
  logic [31:0] lines_sent_q, lines_sent_d;
  logic [31:0] reads_done_q, reads_done_d;

  always_comb begin
    lines_sent_d = lines_sent_q;
    reads_done_d = reads_done_q;
    if (out_valid_c && bus.out_ready) begin
      lines_sent_d = lines_sent_q + 32'd1;
      if (out_last_c) reads_done_d = reads_done_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lines_sent_q <= '0;
      reads_done_q <= '0;
    end else begin
      lines_sent_q <= lines_sent_d;
      reads_done_q <= reads_done_d;
    end
  end

  assign lines_sent = lines_sent_q;
  assign reads_done = reads_done_q;
`else
  assign lines_sent = '0;
  assign reads_done = '0;
`endif

endmodule

// File: tb/tb_smem_mem_drain.sv
module tb_smem_mem_drain;
  localparam int RNW = 6;
`ifdef DRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           finish_sign = 1'b0;
  logic [RNW-1:0] finish_read_num = '0;
  logic [6:0]     finish_mem_size = '0;
  logic           stall_req, overflow;
  logic [31:0]    lines_sent, reads_done;

  always #5 clk = ~clk;

  smem_mem_drain_if #(.RNW(RNW)) bus ();

  smem_mem_drain #(.READ_NUM_WIDTH(RNW), .FIFO_DEPTH(8), .CL(512)) dut (
    .clk             (clk),
    .rst             (rst),
    .finish_sign     (finish_sign),
    .finish_read_num (finish_read_num),
    .finish_mem_size (finish_mem_size),
    .stall_req       (stall_req),
    .overflow        (overflow),
    .lines_sent      (lines_sent),
    .reads_done      (reads_done),
    .bus             (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---- mem buffer model: entry contents derived from (read_num, addr) ----
  function automatic logic [63:0] word_f(input int k, input logic [5:0] rn, input logic [6:0] a);
    logic [31:0] t;
    t = {8'(k + 1), 8'h3C, 2'b00, rn, 1'b0, a};
    return {t, ~t};
  endfunction

  function automatic logic [255:0] half_f(input logic [5:0] rn, input logic [6:0] a);
    return {word_f(3, rn, a), word_f(2, rn, a), word_f(1, rn, a), word_f(0, rn, a)};
  endfunction

  function automatic logic [511:0] hdr_f(input logic [5:0] rn, input logic [6:0] sz);
    logic [511:0] h;
    h = '0;
    h[6:0]  = sz;
    h[12:7] = rn;
    return h;
  endfunction

  logic           rd_pend = 1'b0;
  logic [RNW-1:0] rd_pend_rn = '0;
  logic [6:0]     rd_pend_a = '0;

  always @(negedge clk) begin
    rd_pend    = bus.mem_rd_en;
    rd_pend_rn = bus.mem_rd_read_num;
    rd_pend_a  = bus.mem_rd_addr;
  end

  always @(posedge clk) begin
    if (rd_pend)
      {bus.mem_rd_x_info, bus.mem_rd_x_2, bus.mem_rd_x_1, bus.mem_rd_x_0} <= half_f(rd_pend_rn, rd_pend_a);
    else
      {bus.mem_rd_x_info, bus.mem_rd_x_2, bus.mem_rd_x_1, bus.mem_rd_x_0} <= {4{64'hDEAD_BEEF_DEAD_BEEF}};
  end

  // ---- monitor: accepted lines and issued reads ----
  typedef struct packed {
    logic [511:0]   data;
    logic           last;
    logic [RNW-1:0] rn;
  } line_t;

  typedef struct packed {
    logic [RNW-1:0] rn;
    logic [6:0]     a;
  } rd_t;

  line_t lq[$];
  rd_t   rq[$];

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) lq.push_back({bus.out_data, bus.out_last, bus.out_read_num});
    if (rst && bus.mem_rd_en) rq.push_back({bus.mem_rd_read_num, bus.mem_rd_addr});
  end

  function automatic line_t get_line(input int i);
    if (i < lq.size()) return lq[i];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] rn, input logic [6:0] sz);
    tick();
    finish_sign     = 1'b1;
    finish_read_num = rn;
    finish_mem_size = sz;
    tick();
    finish_sign     = 1'b0;
  endtask

  task automatic wait_lines(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (lq.size() >= n) break;
      tick();
    end
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.out_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           found;
    int           n_last;
    int           max_a;
    int           unstable;
    int           rd_before;
    logic [511:0] snap;

    bus.out_ready = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_out_valid", 512'(bus.out_valid), 512'd0);
    chk("rst_out_data", bus.out_data, 512'd0);
    chk("rst_mem_rd_en", 512'(bus.mem_rd_en), 512'd0);
    chk("rst_stall", 512'(stall_req), 512'd0);
    chk("rst_overflow", 512'(overflow), 512'd0);
    chk("rst_stats", 512'({lines_sent, reads_done}), 512'd0);
    rst = 1'b1;
    repeat (2) tick();

    // ---- rn=5 size=3, sink always ready ----
    bus.out_ready = 1'b1;
    pulse(6'd5, 7'd3);
    wait_lines(3, 100);
    repeat (10) tick();
    chk("s3_line_count", 512'(lq.size()), 512'd3);
    chk("s3_hdr", get_line(0).data, hdr_f(6'd5, 7'd3));
    chk("s3_hdr_last", 512'(get_line(0).last), 512'd0);
    chk("s3_l1_data", get_line(1).data, {half_f(6'd5, 7'd1), half_f(6'd5, 7'd0)});
    chk("s3_l1_last", 512'(get_line(1).last), 512'd0);
    chk("s3_l2_data", get_line(2).data, {256'd0, half_f(6'd5, 7'd2)});
    chk("s3_l2_last", 512'(get_line(2).last), 512'd1);
    chk("s3_l2_rn", 512'(get_line(2).rn), 512'd5);
    chk("s3_rd_count", 512'(rq.size()), 512'd3);
    if (rq.size() == 3) chk("s3_rd_addrs", 512'({rq[0].a, rq[1].a, rq[2].a}), 512'({7'd0, 7'd1, 7'd2}));
    chk("s3_lines_sent", 512'(lines_sent), STATS ? 512'd3 : 512'd0);
    chk("s3_reads_done", 512'(reads_done), STATS ? 512'd1 : 512'd0);
    lq.delete();
    rq.delete();

    // ---- size 0: header only ----
    pulse(6'd9, 7'd0);
    wait_lines(1, 50);
    repeat (10) tick();
    chk("s0_line_count", 512'(lq.size()), 512'd1);
    chk("s0_hdr", get_line(0).data, hdr_f(6'd9, 7'd0));
    chk("s0_hdr_last", 512'(get_line(0).last), 512'd1);
    chk("s0_no_reads", 512'(rq.size()), 512'd0);
    lq.delete();
    rq.delete();

    // ---- size 127: 65 lines ----
    pulse(6'd33, 7'd127);
    wait_lines(65, 1000);
    repeat (10) tick();
    chk("s127_line_count", 512'(lq.size()), 512'd65);
    n_last = 0;
    foreach (lq[i]) if (lq[i].last) n_last++;
    chk("s127_last_count", 512'(n_last), 512'd1);
    chk("s127_final_last", 512'(get_line(64).last), 512'd1);
    chk("s127_final_data", get_line(64).data, {256'd0, half_f(6'd33, 7'd126)});
    chk("s127_l10_data", get_line(10).data, {half_f(6'd33, 7'd19), half_f(6'd33, 7'd18)});
    chk("s127_rd_count", 512'(rq.size()), 512'd127);
    max_a = 0;
    foreach (rq[i]) if (int'(rq[i].a) > max_a) max_a = int'(rq[i].a);
    chk("s127_max_addr", 512'(max_a), 512'd126);
    lq.delete();
    rq.delete();

    // ---- back-pressure for 10 cycles on a data line ----
    pulse(6'd12, 7'd4);
    wait_lines(1, 50);
    bus.out_ready = 1'b0;
    wait_valid(50, found);
    chk("bp_valid_seen", 512'(found), 512'd1);
    snap      = bus.out_data;
    rd_before = rq.size();
    unstable  = 0;
    repeat (10) begin
      tick();
      if (bus.out_data !== snap || bus.out_valid !== 1'b1) unstable++;
    end
    chk("bp_held_data", snap, {half_f(6'd12, 7'd1), half_f(6'd12, 7'd0)});
    chk("bp_unstable_cycles", 512'(unstable), 512'd0);
    chk("bp_reads_during_stall", 512'(rq.size()), 512'(rd_before));
    chk("bp_reads_before", 512'(rd_before), 512'd2);
    bus.out_ready = 1'b1;
    wait_lines(3, 100);
    repeat (10) tick();
    chk("bp_line_count", 512'(lq.size()), 512'd3);
    chk("bp_l2_data", get_line(2).data, {half_f(6'd12, 7'd3), half_f(6'd12, 7'd2)});
    chk("bp_l2_last", 512'(get_line(2).last), 512'd1);
    chk("bp_rd_count", 512'(rq.size()), 512'd4);
    lq.delete();
    rq.delete();

    // ---- FIFO fill with the sink blocked ----
    bus.out_ready = 1'b0;
    pulse(6'd19, 7'd0);
    wait_valid(20, found);
    chk("ff_busy_hdr", 512'(found), 512'd1);
    for (int i = 0; i < 9; i++) begin
      if (i == 6) chk("ff_stall_at6", 512'(stall_req), 512'd0);
      if (i == 7) chk("ff_stall_at7", 512'(stall_req), 512'd1);
      if (i == 8) chk("ff_ovf_before9", 512'(overflow), 512'd0);
      finish_sign     = 1'b1;
      finish_read_num = 6'(20 + i);
      finish_mem_size = 7'd1;
      tick();
    end
    finish_sign = 1'b0;
    chk("ff_ovf_after9", 512'(overflow), 512'd1);
    chk("ff_stall_full", 512'(stall_req), 512'd1);
    bus.out_ready = 1'b1;
    wait_lines(17, 500);
    repeat (10) tick();
    chk("ff_line_count", 512'(lq.size()), 512'd17);
    chk("ff_last_hdr", get_line(15).data, hdr_f(6'd27, 7'd1));
    chk("ff_last_data", get_line(16).data, {256'd0, half_f(6'd27, 7'd0)});
    chk("ff_last_rn", 512'(get_line(16).rn), 512'd27);
    chk("ff_ovf_sticky", 512'(overflow), 512'd1);
    chk("ff_stall_drained", 512'(stall_req), 512'd0);
    lq.delete();
    rq.delete();

    // ---- reset during EMIT ----
    pulse(6'd40, 7'd4);
    wait_lines(1, 50);
    bus.out_ready = 1'b0;
    wait_valid(50, found);
    chk("rr_emit_seen", 512'(found), 512'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("rr_out_valid", 512'(bus.out_valid), 512'd0);
    chk("rr_out_data", bus.out_data, 512'd0);
    chk("rr_out_last", 512'({bus.out_last, bus.out_read_num}), 512'd0);
    chk("rr_mem_rd_en", 512'(bus.mem_rd_en), 512'd0);
    chk("rr_overflow", 512'(overflow), 512'd0);
    chk("rr_stall", 512'(stall_req), 512'd0);
    chk("rr_stats", 512'({lines_sent, reads_done}), 512'd0);
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    lq.delete();
    rq.delete();
    pulse(6'd41, 7'd2);
    wait_lines(2, 50);
    repeat (10) tick();
    chk("rr_line_count", 512'(lq.size()), 512'd2);
    chk("rr_hdr", get_line(0).data, hdr_f(6'd41, 7'd2));
    chk("rr_l1_data", get_line(1).data, {half_f(6'd41, 7'd1), half_f(6'd41, 7'd0)});
    chk("rr_l1_last", 512'(get_line(1).last), 512'd1);
    chk("rr_lines_sent", 512'(lines_sent), STATS ? 512'd2 : 512'd0);
    chk("rr_reads_done", 512'(reads_done), STATS ? 512'd1 : 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
